// File: rtl/serial_addsub_ctrl_if.sv
// Request/result bundle between a requester and the bit-serial add/subtract unit.
// The master drives operands and start; the slave returns status and the registered result.
interface serial_addsub_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             ovf;
   logic             neg;
   logic             zero;

   modport master (
      output start, sub, a, b,
      input  busy, done, s, cout, ovf, neg, zero
   );

   modport slave (
      input  start, sub, a, b,
      output busy, done, s, cout, ovf, neg, zero
   );
endinterface

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial two's-complement add/subtract: one full-adder slice is stepped LSB-first over
// WIDTH cycles by a three-state controller, then the result and flags are loaded together.
module serial_addsub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   serial_addsub_ctrl_if.slave bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic             accept;
   logic             last;

   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_next;
   logic             carry;
   logic             carry_next;
   logic             sum_bit;
   logic [CW-1:0]    cnt;

   logic [WIDTH-1:0] s_q;
   logic             cout_q;
   logic             ovf_q;
   logic             neg_q;
   logic             zero_q;

   // NOTE: state and datapath registers use non-blocking assignments so every flop
   // samples pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: every output of this block gets a default before the case, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      last       = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               accept     = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (cnt == CW'(WIDTH - 1)) begin
               last       = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            if (bus.start) begin
               accept     = 1'b1;
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // One full-adder slice on the current LSBs; the sum enters the accumulator at the MSB.
   always_comb begin
      sum_bit    = op_a[0] ^ op_b[0] ^ carry;
      carry_next = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
      acc_next   = {sum_bit, acc[WIDTH-1:1]};
   end

   // Subtraction is A + ~B + 1: B is inverted at capture and the +1 rides in as carry-in.
   // carry still holds the carry into the MSB on the last step, which yields ovf directly.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_a   <= '0;
         op_b   <= '0;
         acc    <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         s_q    <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         neg_q  <= 1'b0;
         zero_q <= 1'b0;
      end else if (accept) begin
         op_a  <= bus.a;
         op_b  <= bus.sub ? ~bus.b : bus.b;
         acc   <= '0;
         carry <= bus.sub;
         cnt   <= '0;
      end else if (state == RUN) begin
         op_a  <= op_a >> 1;
         op_b  <= op_b >> 1;
         acc   <= acc_next;
         carry <= carry_next;
         cnt   <= cnt + CW'(1);
         if (last) begin
            s_q    <= acc_next;
            cout_q <= carry_next;
            ovf_q  <= carry ^ carry_next;
            neg_q  <= acc_next[WIDTH-1];
            zero_q <= (acc_next == '0);
         end
      end
   end

   assign bus.busy = (state == RUN);
   assign bus.done = (state == DONE);
   assign bus.s    = s_q;
   assign bus.cout = cout_q;
   assign bus.ovf  = ovf_q;
   assign bus.neg  = neg_q;
   assign bus.zero = zero_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed and random checks of serial_addsub_ctrl against an integer-arithmetic model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_serial_addsub_ctrl;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] s;
      logic         cout;
      logic         ovf;
      logic         neg;
      logic         zero;
   } res_t;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;
   logic [W-1:0] last_s;

   serial_addsub_ctrl_if #(.WIDTH(W)) bus ();

   serial_addsub_ctrl #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      res_t r;
      int   sa, sb, sr, ua, ub;
      logic [W-1:0] sv;
      sa = $signed(a);
      sb = $signed(b);
      ua = int'(a);
      ub = int'(b);
      sr = sub ? (sa - sb) : (sa + sb);
      sv = W'(sr);
      r.s    = sv;
      r.cout = sub ? (ua >= ub) : ((ua + ub) >= (1 << W));
      r.ovf  = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
      r.neg  = sv[W-1];
      r.zero = (sv == '0);
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic sub);
      res_t e;
      e = model(a, b, sub);
      check({tag, ".done"}, 32'(bus.done), 32'd1);
      check({tag, ".s"},    32'(bus.s),    32'(e.s));
      check({tag, ".cout"}, 32'(bus.cout), 32'(e.cout));
      check({tag, ".ovf"},  32'(bus.ovf),  32'(e.ovf));
      check({tag, ".neg"},  32'(bus.neg),  32'(e.neg));
      check({tag, ".zero"}, 32'(bus.zero), 32'(e.zero));
      last_s = e.s;
   endtask

   // Called at a falling edge; returns at the first falling edge after the accept edge,
   // with the operand inputs scrambled to show they were captured at accept.
   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      bus.a     = a;
      bus.b     = b;
      bus.sub   = sub;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      bus.sub   = 1'($urandom);
   endtask

   task automatic wait_done(inout int cyc);
      while (bus.done !== 1'b1 && cyc < 4 * W) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub);
      int cyc;
      launch(a, b, sub);
      check({tag, ".busy"}, 32'(bus.busy), 32'd1);
      check({tag, ".hold"}, 32'(bus.s), 32'(last_s));
      cyc = 0;
      wait_done(cyc);
      check({tag, ".latency"}, 32'(cyc), 32'(W));
      check_result(tag, a, b, sub);
      @(negedge clk);
      check({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
      check({tag, ".idle"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int cyc;
      int seen;
      logic [W-1:0] ra, rb;
      logic rs;

      n_cmp     = 0;
      n_err     = 0;
      last_s    = '0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.sub   = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (2) @(negedge clk);
      check("reset.busy", 32'(bus.busy), 32'd0);
      check("reset.done", 32'(bus.done), 32'd0);
      check("reset.s",    32'(bus.s),    32'd0);
      check("reset.flags", 32'({bus.cout, bus.ovf, bus.neg, bus.zero}), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed arithmetic cases, including both overflow directions and a zero result.
      do_op("add_neg",   8'h9C, 8'h35, 1'b0);
      do_op("add_ovf",   8'd100, 8'd53, 1'b0);
      do_op("sub_ovf",   8'h80, 8'h01, 1'b1);
      do_op("sub_zero",  8'd5, 8'd5, 1'b1);
      do_op("sub_borrow", 8'd3, 8'd5, 1'b1);
      do_op("add_carry", 8'hFF, 8'h01, 1'b0);

      // start during RUN is ignored; the old result holds until completion.
      launch(8'd1, 8'd2, 1'b0);
      cyc = 1;
      repeat (3) begin
         @(negedge clk);
         cyc++;
      end
      bus.a     = 8'd7;
      bus.b     = 8'd7;
      bus.start = 1'b1;
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      check("ignore.hold", 32'(bus.s), 32'(last_s));
      check("ignore.busy", 32'(bus.busy), 32'd1);
      wait_done(cyc);
      check("ignore.latency", 32'(cyc), 32'(W + 1));
      check_result("ignore", 8'd1, 8'd2, 1'b0);
      @(negedge clk);
      check("ignore.idle", 32'(bus.busy), 32'd0);

      // Back-to-back: start in the DONE cycle, next done exactly WIDTH+1 cycles later.
      launch(8'd20, 8'd30, 1'b0);
      cyc = 0;
      wait_done(cyc);
      check_result("b2b_first", 8'd20, 8'd30, 1'b0);
      bus.a     = 8'h90;
      bus.b     = 8'h20;
      bus.sub   = 1'b1;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("b2b.busy", 32'(bus.busy), 32'd1);
      cyc = 1;
      wait_done(cyc);
      check("b2b.spacing", 32'(cyc), 32'(W + 1));
      check_result("b2b_second", 8'h90, 8'h20, 1'b1);
      @(negedge clk);

      // Reset in the middle of RUN aborts and clears everything.
      launch(8'h40, 8'h0F, 1'b0);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort.busy", 32'(bus.busy), 32'd0);
      check("abort.done", 32'(bus.done), 32'd0);
      check("abort.s",    32'(bus.s),    32'd0);
      check("abort.flags", 32'({bus.cout, bus.ovf, bus.neg, bus.zero}), 32'd0);
      seen = 0;
      repeat (2 * W) begin
         @(negedge clk);
         if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
      end
      check("abort.quiet", 32'(seen), 32'd0);
      last_s = '0;
      do_op("after_abort", 8'h11, 8'h22, 1'b0);

      // start together with rst: the request is dropped.
      rst       = 1'b1;
      bus.start = 1'b1;
      bus.a     = 8'd9;
      bus.b     = 8'd9;
      @(negedge clk);
      rst       = 1'b0;
      bus.start = 1'b0;
      check("rst_start.busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      check("rst_start.busy2", 32'(bus.busy), 32'd0);
      check("rst_start.s", 32'(bus.s), 32'd0);
      last_s = '0;

      // Random operands and operations.
      for (int i = 0; i < 40; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rs = 1'($urandom);
         do_op($sformatf("rand%0d", i), ra, rb, rs);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
